// File: rtl/vjtag_pkg.sv
// Definitions shared by the virtual-JTAG hub clients (LED client and readback block).
package vjtag_pkg;

  localparam logic [1:0] IR_LEDS   = 2'b01;
  localparam logic [1:0] IR_READ   = 2'b10;
  localparam logic [1:0] IR_STATUS = 2'b11;

  // Flops between an asynchronous hub signal and its first use.
  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [0:0] {
    StArmed,
    StCaptured
  } cap_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; full/empty derived from the occupancy count.
module sync_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [CntW-1:0]   count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok) begin
        count_q <= count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/vjtag_readback.sv
// FPGA-to-host readback over the virtual JTAG hub: fabric pushes words, host pops them
// via IR_READ scans and reads/clears the overflow flag via IR_STATUS scans.
module vjtag_readback
  import vjtag_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CNT_W     = 5,
  parameter logic [1:0]  IR_READ   = vjtag_pkg::IR_READ,
  parameter logic [1:0]  IR_STATUS = vjtag_pkg::IR_STATUS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tck,
  input  logic              tdi,
  input  logic [1:0]        ir_in,
  input  logic              virtual_state_cdr,
  input  logic              virtual_state_sdr,
  input  logic              virtual_state_udr,
  output logic              tdo,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow
);

  localparam int unsigned SyncW = 7;

  logic [SyncW-1:0] pins;
  logic [SyncW-1:0] sync_q [SYNC_STAGES];
  logic             tck_s;
  logic             tdi_s;
  logic [1:0]       ir_s;
  logic             cdr_s;
  logic             sdr_s;
  logic             udr_s;
  logic             tck_prev_q;
  logic             tck_rise;

  assign pins = {tck, tdi, ir_in, virtual_state_cdr, virtual_state_sdr, virtual_state_udr};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      tck_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= pins;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      tck_prev_q <= tck_s;
    end
  end

  assign {tck_s, tdi_s, ir_s, cdr_s, sdr_s, udr_s} = sync_q[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_prev_q;

  logic sel_read;
  logic sel_status;
  logic active;

  assign sel_read   = (ir_s == IR_READ);
  assign sel_status = (ir_s == IR_STATUS);
  assign active     = sel_read | sel_status;

  logic              fifo_push;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_dout;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_full;
  logic              fifo_empty;

  // One capture per CDR visit: re-armed by the first tck edge seen outside CDR.
  cap_state_e cap_state_q, cap_state_d;
  logic       capture;

  always_comb begin
    cap_state_d = cap_state_q;
    capture     = 1'b0;
    if (tck_rise && active) begin
      if (cdr_s) begin
        if (cap_state_q == StArmed) begin
          capture     = 1'b1;
          cap_state_d = StCaptured;
        end
      end else begin
        cap_state_d = StArmed;
      end
    end
  end

  logic [DATA_W:0] shreg_q, shreg_d;
  logic            do_shift;
  logic            ov_set;
  logic            ov_clear;
  logic            overflow_q, overflow_d;

  assign do_shift = tck_rise & active & sdr_s;
  assign ov_set   = wr_valid & fifo_full;
  assign ov_clear = tck_rise & sel_status & udr_s & shreg_q[0];

  always_comb begin
    shreg_d = shreg_q;
    if (capture) begin
      if (sel_status) begin
        shreg_d = {{(DATA_W-CNT_W-1){1'b0}}, overflow_q, fifo_cnt, 1'b1};
      end else if (!fifo_empty) begin
        shreg_d = {fifo_dout, 1'b1};
      end else begin
        shreg_d = '0;
      end
    end else if (do_shift) begin
      shreg_d = {tdi_s, shreg_q[DATA_W:1]};
    end
  end

  // A new overflow in the same cycle as a host clear wins.
  always_comb begin
    overflow_d = overflow_q;
    if (ov_set) begin
      overflow_d = 1'b1;
    end else if (ov_clear) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_state_q <= StArmed;
      shreg_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      cap_state_q <= cap_state_d;
      shreg_q     <= shreg_d;
      overflow_q  <= overflow_d;
    end
  end

  assign fifo_pop  = capture & sel_read & ~fifo_empty;
  assign wr_ready  = ~fifo_full & ~reset;
  assign fifo_push = wr_valid & wr_ready;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (wr_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tdo        = active & shreg_q[0];
  assign fifo_count = fifo_cnt;
  assign overflow   = overflow_q;

endmodule

// File: doc/vjtag_readback.md
Name: vjtag_readback

Overview:
- FPGA-to-host companion of the existing host-to-FPGA virtual-JTAG LED client: fabric logic pushes words into a small FIFO and the host reads them out through the same virtual JTAG hub instance.
- Runs entirely on clk. The virtual-JTAG tck, state and ir signals are treated as slow asynchronous inputs and oversampled, so no second clock domain exists.
- Sits beside the LED client in top. Its tdo is muxed onto the hub tdo by ir_in.

Parameters:
- DATA_W, 32, width of one FIFO word.
- DEPTH, 16, FIFO depth in words; must be a power of 2, minimum 2.
- CNT_W, 5, width of the occupancy counter, equal to log2(DEPTH)+1.
- IR_READ, 2'b10, IR code that pops and reads the FIFO head.
- IR_STATUS, 2'b11, IR code that reads and clears status.

Ports:
- clk  in  1  system clock; tck must be at least 8 clk periods.
- reset  in  1  synchronous, active-high reset.
- tck  in  1  virtual-JTAG TCK (asynchronous).
- tdi  in  1  virtual-JTAG TDI (asynchronous).
- ir_in  in  2  virtual IR value (asynchronous).
- virtual_state_cdr  in  1  Capture-DR state.
- virtual_state_sdr  in  1  Shift-DR state.
- virtual_state_udr  in  1  Update-DR state.
- tdo  out  1  serial data to the hub.
- wr_valid  in  1  fabric push request.
- wr_data  in  DATA_W  fabric push word.
- wr_ready  out  1  FIFO not full.
- fifo_count  out  CNT_W  current FIFO occupancy.
- overflow  out  1  sticky flag: a push was attempted while the FIFO was full.

Behaviour:
- Reset, applied synchronously on the next clk edge:
  - FIFO pointers, count and all synchronizers cleared.
  - Shift register cleared, so tdo=0.
  - overflow=0, fifo_count=0.
  - wr_ready=0 while reset is high, then 1.
- Input synchronization:
  - tck, tdi, ir_in, cdr, sdr and udr each pass through 2 flops.
  - A third tck flop provides edge detection.
  - tck_rise = synced tck is 1 and the previous sample was 0.
  - Total latency from a pin edge to an action is 3 clk.
- Selection: the block acts only when synced ir_in is IR_READ or IR_STATUS. For any other IR it ignores all JTAG activity and holds tdo at 0.
- Shift register: DATA_W+1 bits, LSB shifted out first, tdo = shreg[0].
- Capture (first tck_rise with cdr=1):
  - IR_READ, FIFO not empty: shreg = {head word, 1'b1}; head is popped in the same clk.
  - IR_READ, FIFO empty: shreg = {0, 1'b0}; no pop; overflow unaffected.
  - IR_STATUS: shreg = {zero-extended {overflow, fifo_count}, 1'b1}.
- Shift (tck_rise with sdr=1): shreg = {tdi, shreg[DATA_W:1]}. tdo changes about 3 clk after the rising edge, well before the host's next sampling edge.
- Update (tck_rise with udr=1) under IR_STATUS: if shreg[0]=1, overflow is cleared. A clear in the same clk as a new overflow leaves overflow=1 (set wins).
- FIFO behaviour:
  - wr_ready = !full.
  - A push occurs when wr_valid and wr_ready are both high.
  - wr_valid while full: word dropped, overflow set to 1 (sticky).
  - Push and pop in the same clk: both occur and count is unchanged. When the FIFO is full, the push is still rejected in that clk (wr_ready is registered-free and combinational from the count).
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Only one capture happens per CDR visit. Repeated cdr samples without an intervening tck_rise have no effect.
- Reset during a DR shift: shreg zeroed and the rest of that shift reads 0s. No spurious pop after reset is released until the next CDR.

Decomposition:
- Shared package vjtag_pkg:
  - IR code constants: IR_LEDS=2'b01, IR_READ, IR_STATUS.
  - Shared synchronizer depth constant.
  - Used by both the LED client and this block.
- One sub-module, sync_fifo: parameterised by DATA_W and DEPTH; ports clk, reset, push, din, pop, dout, count, full, empty.
- Synchronizers and the shift logic stay inline.

Test Plan:
- After reset, push 0xDEADBEEF then 0x12345678. IR_READ, CDR, 33 shifts → host sees bit0=1 then 0xDEADBEEF LSB-first; fifo_count goes 2→1 three clk after the capture edge.
- Empty FIFO, IR_READ capture and 33 shifts → all 33 bits are 0; fifo_count stays 0; overflow stays 0.
- Push 17 words with DEPTH=16 → wr_ready=0 after the 16th push, overflow=1, fifo_count=16. Reading back returns words 1..16 in order.
- IR_STATUS read after the overflow case → shreg returns bit0=1 and bits[CNT_W+1:1]={1, 16}. Shifting tdi=1 then UDR → overflow=0.
- Full FIFO with a push and a capture-pop in the same clk → pop occurs, push is rejected, overflow=1, count=15.
- Assert reset mid-shift after 10 bits → tdo=0 on the next clk, fifo_count=0. Subsequent shifts read 0. The next CDR with IR_READ on the empty FIFO gives valid bit=0.
